// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO packers.
// - NIB_W    : nibble width
// - pk_state_e : packer FSM states
// - slot_lsb : maps an accumulator slot index to its bit offset
package fifo_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } pk_state_e;

  // Slot 0 is the first nibble of a word; msb_first puts it at the top.
  function automatic int unsigned slot_lsb(input int unsigned slot,
                                           input int unsigned nibbles,
                                           input bit          msb_first);
    return msb_first ? NIB_W * (nibbles - 1 - slot) : NIB_W * slot;
  endfunction
endpackage

// File: rtl/fifo_nibble_packer_if.sv
// Bundle between the nibble packer, the upstream FIFO read port and the
// downstream word sink.
// master : packer side (drives fifo_rd_en and the word port)
// slave  : environment side (FIFO flags/data, flush, word_ready)
interface fifo_nibble_packer_if
  import fifo_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIB_W * NIBBLES;

  logic             fifo_empty;
  logic [NIB_W-1:0] fifo_rd;
  logic             fifo_rd_en;
  logic             flush;
  logic [W-1:0]     word_out;
  logic             word_valid;
  logic             word_ready;
  logic             word_partial;
  logic [3:0]       word_nibs;
  logic [15:0]      words_sent;

  modport master (
    input  fifo_empty, fifo_rd, flush, word_ready,
    output fifo_rd_en, word_out, word_valid, word_partial, word_nibs, words_sent
  );

  modport slave (
    output fifo_empty, fifo_rd, flush, word_ready,
    input  fifo_rd_en, word_out, word_valid, word_partial, word_nibs, words_sent
  );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Read-side consumer for the 8x4 async FIFO: pulls nibbles, packs NIBBLES of
// them into a word and offers it on a valid/ready port. A flush emits any
// partial word zero-padded.
// Ports:
//   clk_rd : read-domain clock
//   reset  : asynchronous active-low reset
//   bus    : fifo_nibble_packer_if.master (FIFO read port, flush, word port)
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk_rd,
  input logic                  reset,
  fifo_nibble_packer_if.master bus
);
  localparam int W = NIB_W * NIBBLES;

  pk_state_e    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         inflight_q, inflight_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] word_out_q, word_out_d;
  logic         word_valid_q, word_valid_d;
  logic         word_partial_q, word_partial_d;
  logic [3:0]   word_nibs_q, word_nibs_d;
  logic [15:0]  words_sent_q, words_sent_d;
  logic         rd_en, out_free, load;

  // cnt + inflight bound keeps the accumulator from overflowing; flush wins
  // over a read in the same cycle. word_ready is deliberately not used here.
  assign rd_en = reset && !bus.fifo_empty && (state_q == FILL) && !bus.flush &&
                 ((32'(cnt_q) + 32'(inflight_q)) < 32'(NIBBLES));

  assign out_free = !word_valid_q || bus.word_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    inflight_d     = rd_en;
    word_out_d     = word_out_q;
    word_valid_d   = word_valid_q;
    word_partial_d = word_partial_q;
    word_nibs_d    = word_nibs_q;
    load           = 1'b0;

    // Data of an accepted read arrives one cycle later, in any state.
    if (inflight_q) begin
      acc_d[slot_lsb(32'(cnt_q), NIBBLES, MSB_FIRST) +: NIB_W] = bus.fifo_rd;
      cnt_d = cnt_q + 4'd1;
    end

    unique case (state_q)
      // Looking at cnt_d lets FULL start the cycle after the last capture.
      FILL: begin
        if (32'(cnt_d) == NIBBLES) state_d = FULL;
        else if (bus.flush)        state_d = DRAIN;
      end
      FULL: begin
        if (out_free) load = 1'b1;
      end
      DRAIN: begin
        if (!inflight_q) begin
          if (cnt_q == 4'd0) state_d = FILL;
          else if (out_free) load = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    // Unfilled slots are already zero because acc is cleared on every load.
    if (load) begin
      word_out_d     = acc_q;
      word_valid_d   = 1'b1;
      word_partial_d = (32'(cnt_q) != NIBBLES);
      word_nibs_d    = cnt_q;
      acc_d          = '0;
      cnt_d          = 4'd0;
      state_d        = FILL;
    end else if (bus.word_ready) begin
      word_valid_d = 1'b0;
    end

    words_sent_d = words_sent_q + 16'(word_valid_q && bus.word_ready);
  end

  always_ff @(posedge clk_rd or negedge reset) begin
    if (!reset) begin
      state_q        <= FILL;
      cnt_q          <= '0;
      inflight_q     <= 1'b0;
      acc_q          <= '0;
      word_out_q     <= '0;
      word_valid_q   <= 1'b0;
      word_partial_q <= 1'b0;
      word_nibs_q    <= '0;
      words_sent_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inflight_q     <= inflight_d;
      acc_q          <= acc_d;
      word_out_q     <= word_out_d;
      word_valid_q   <= word_valid_d;
      word_partial_q <= word_partial_d;
      word_nibs_q    <= word_nibs_d;
      words_sent_q   <= words_sent_d;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.word_out     = word_out_q;
  assign bus.word_valid   = word_valid_q;
  assign bus.word_partial = word_partial_q;
  assign bus.word_nibs    = word_nibs_q;
  assign bus.words_sent   = words_sent_q;
endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
- Read-domain consumer placed directly downstream of the team's 8-deep x 4-bit asynchronous FIFO.
- Drives the FIFO read enable and captures each nibble the cycle after the read is accepted.
- Packs NIBBLES nibbles into one word and presents it on a valid/ready output port.
- Supports a flush request that emits a zero-padded partial word, so trailing data is never stranded.

Parameters:
- NIBBLES, 4: nibbles per output word; word width W = 4*NIBBLES; legal range 2..8.
- MSB_FIRST, 1: 1 places the first nibble in bits [W-1:W-4]; 0 places it in bits [3:0].

Ports:
- clk_rd, input, 1: read-domain clock, the same clock as the FIFO read side.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd, input, 4: FIFO read data, updated on the edge that accepts a read.
- fifo_rd_en, output, 1: FIFO read request, combinational.
- flush, input, 1: single-cycle request to emit any partial word.
- word_out, output, W: packed word.
- word_valid, output, 1: word_out holds a word.
- word_ready, input, 1: sink accepts the word.
- word_partial, output, 1: current word was produced by a flush.
- word_nibs, output, 4: count of valid nibbles in word_out (1..NIBBLES).
- words_sent, output, 16: count of accepted words, wraps at 65535 to 0.

Behaviour:
- Reset values: word_out=0, word_valid=0, word_partial=0, word_nibs=0, words_sent=0, cnt=0, inflight=0, state=FILL.
- fifo_rd_en is forced to 0 while reset is low.
- The FIFO accepts a read only when fifo_rd_en=1 and fifo_empty=0. Its data is valid on fifo_rd in the following cycle.
- Internal accumulator: acc[W-1:0] and cnt (0..NIBBLES).
  - inflight is a registered copy of (fifo_rd_en && !fifo_empty).
  - When inflight=1, fifo_rd is written into acc slot cnt and cnt increments.
- Slot mapping:
  - MSB_FIRST=1: slot k occupies bits [W-1-4k : W-4-4k].
  - MSB_FIRST=0: slot k occupies bits [4k+3 : 4k].
- fifo_rd_en = !fifo_empty && state==FILL && (cnt + inflight < NIBBLES).
  - The accumulator therefore never overflows.
  - Steady-state throughput is NIBBLES nibbles per NIBBLES+2 cycles.
- Output register: a word is loaded only when (!word_valid || word_ready) in the same cycle, so back-to-back transfer is allowed.
  - On load, word_valid=1.
  - word_out, word_partial and word_nibs are held stable while word_valid && !word_ready.
  - A handshake with no new load clears word_valid next cycle.
  - words_sent increments on every word_valid && word_ready cycle.
- FSM:
  - FILL: issue reads. If cnt==NIBBLES, go to FULL. If flush=1, go to DRAIN; a flush takes priority over issuing a read in that cycle.
  - FULL: no reads are issued. When the output register is free, load acc and set word_partial=0, word_nibs=NIBBLES. Then clear cnt and acc and return to FILL.
  - DRAIN: no reads are issued. Wait until inflight=0, which takes at most 1 cycle.
    - If cnt=0, return to FILL with no output.
    - If cnt=NIBBLES, behave as FULL with word_partial=0.
    - Otherwise, when the output register is free, load acc with unfilled slots at 0, set word_partial=1 and word_nibs=cnt, then clear and return to FILL.
- A flush arriving in FULL or DRAIN is ignored.
- If flush arrives when cnt + inflight = 0, the block passes through DRAIN for one cycle and emits nothing.
- A fifo_empty rise while inflight=1 does not affect capture: the in-flight nibble is still taken.
- Reset asserted mid-word discards acc, inflight and any held output word immediately.
  - The FIFO pointer is reset by its own reset, so no resync is needed.
- No combinational path from word_ready to fifo_rd_en.

Decomposition:
- Shared package fifo_pkg holds:
  - NIB_W=4.
  - The packer state enum {FILL, FULL, DRAIN}.
  - The slot-index-to-bit-offset function, shared with the write-side packer/unpacker.
- No sub-module; the accumulator, FSM and output register form one block.

Test Plan:
- Reset, then FIFO preloaded with 1,2,3,4 and word_ready=1 -> word_out=16'h1234, word_valid for 1 cycle, word_nibs=4, word_partial=0, words_sent=1. fifo_rd_en is high on exactly 4 cycles.
- Same stimulus with MSB_FIRST=0 -> word_out=16'h4321.
- FIFO holds A,B; flush pulses after both are captured -> word_out=16'hAB00, word_partial=1, word_nibs=2. No further reads occur while in DRAIN.
- 12 nibbles 0..B streamed with word_ready=0 for 20 cycles, then 1 -> first word 16'h0123 is held stable throughout the stall, and fifo_rd_en stays low once acc is full. Then 16'h4567 and 16'h89AB follow; no nibble is lost or duplicated.
- fifo_empty toggling every cycle over 8 nibbles -> fifo_rd_en is never high while fifo_empty=1, and two correct words are produced.
- reset driven low while cnt=3 with a word held -> all outputs return to 0 asynchronously. After release, the next 4 nibbles form a fresh word.
